// File: rtl/if_stage.sv
// Instruction fetch stage: issues one SRAM read per cycle, buffers the returned
// word while decode back-pressures, and remembers a branch target it could not take yet.
module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allow_in,
  input  logic [33:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  localparam logic [31:0] RESET_PC = 32'h1bfffffc;

  logic [31:0] r_fs_pc;
  logic        r_fs_valid;
  logic [31:0] r_inst_buf;
  logic        r_inst_buf_valid;
  logic        r_br_pending;
  logic [31:0] r_br_pending_target;

  logic        w_br_stall;
  logic        w_br_taken;
  logic [31:0] w_br_target;
  logic [31:0] w_seq_pc;
  logic [31:0] w_nextpc;
  logic        w_fs_allow_in;
  logic        w_take_now;
  logic [31:0] w_fs_inst;

  assign w_br_stall  = br_bus[33];
  assign w_br_taken  = br_bus[32];
  assign w_br_target = br_bus[31:0];

  assign w_seq_pc   = r_fs_pc + 32'd4;
  assign w_take_now = w_br_taken && !w_br_stall;

  always_comb begin
    w_nextpc = w_seq_pc;
    if (w_take_now)
      w_nextpc = w_br_target;
    else if (r_br_pending)
      w_nextpc = r_br_pending_target;
  end

  assign w_fs_allow_in = !w_br_stall && (!r_fs_valid || ds_allow_in);

  assign inst_sram_en    = !reset && w_fs_allow_in;
  assign inst_sram_addr  = w_nextpc;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_wdata = 32'b0;

  // The SRAM only presents the word for one cycle, so keep the first one seen under back-pressure.
  assign w_fs_inst      = r_inst_buf_valid ? r_inst_buf : inst_sram_rdata;
  assign fs_to_ds_valid = r_fs_valid;
  assign fs_ds_bus      = {r_fs_pc, w_fs_inst};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fs_pc             <= RESET_PC;
      r_fs_valid          <= 1'b0;
      r_inst_buf          <= 32'b0;
      r_inst_buf_valid    <= 1'b0;
      r_br_pending        <= 1'b0;
      r_br_pending_target <= 32'b0;
    end else if (!w_br_stall) begin
      if (w_fs_allow_in) begin
        r_fs_pc    <= w_nextpc;
        r_fs_valid <= 1'b1;
      end

      if (r_fs_valid && ds_allow_in) begin
        r_inst_buf_valid <= 1'b0;
      end else if (r_fs_valid && !r_inst_buf_valid) begin
        r_inst_buf       <= inst_sram_rdata;
        r_inst_buf_valid <= 1'b1;
      end

      // A redirect that arrives while fetch is blocked waits here; the newest one wins.
      if (w_fs_allow_in) begin
        r_br_pending <= 1'b0;
      end else if (w_take_now) begin
        r_br_pending        <= 1'b1;
        r_br_pending_target <= w_br_target;
      end
    end
  end

endmodule
